// File: rtl/hex_printer_pkg.sv
// Shared constants for the hex printer: FSM state encoding and ASCII codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hex_printer_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIGIT = 2'd1;
  localparam logic [1:0] ST_TERM  = 2'd2;

  // ASCII characters emitted by the printer
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

endpackage

// File: rtl/hex_printer_if.sv
// Word-in / character-out handshake bundle of the hex printer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the word port and the character port.
interface hex_printer_if;
  logic [31:0] din;
  logic        nl;
  logic        vld_in;
  logic        rdy_in;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic        busy;

  // word producer and character consumer side
  modport master (
    output din, nl, vld_in, rdy_tx,
    input  rdy_in, d_tx, vld_tx, busy
  );

  // printer side
  modport slave (
    input  din, nl, vld_in, rdy_tx,
    output rdy_in, d_tx, vld_tx, busy
  );
endinterface

// File: rtl/hex_printer_hex2ascii.sv
// Maps one nibble to its uppercase ASCII hex digit.
// Latency: combinational.
// Backpressure: none.
module hex2ascii
  import hex_printer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  // 0..9 count up from '0', 10..15 count up from 'A'
  always_comb begin
    if (nib_i < 4'd10) asc_o = ASC_0 + {4'd0, nib_i};
    else               asc_o = ASC_A + {4'd0, nib_i} - 8'd10;
  end

endmodule

// File: rtl/hex_printer.sv
// Prints a latched word as DIGITS uppercase hex characters followed by CR LF or a space.
// Latency: first character valid 1 cycle after the word is accepted.
// Backpressure: holds d_tx/vld_tx while rdy_tx is low; rdy_in low for the whole print.
module hex_printer
  import hex_printer_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  hex_printer_if.slave  bus
);

  localparam int CW = $clog2(DIGITS + 2);
  localparam int WW = 4 * DIGITS;

  // cnt_q walks the digits 0..DIGITS-1, then DIGITS (CR or SP) and DIGITS+1 (LF)
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW:0]   data_q, data_d;   // {nl, word}
  logic [3:0]    nib;
  logic [7:0]    nib_asc;
  logic          nl_q;
  logic          unused_din;

  assign nl_q       = data_q[WW];
  assign unused_din = ^bus.din;

  // pick the nibble at the counter position, most-significant nibble first
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) nib = data_q[4*(DIGITS-1-i) +: 4];
    end
  end

  hex2ascii u_hex2ascii (
    .nib_i (nib),
    .asc_o (nib_asc)
  );

  // next-state: accept in IDLE, step one character per accepted transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.vld_in) begin
          data_d  = {bus.nl, bus.din[WW-1:0]};
          cnt_d   = '0;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (bus.rdy_tx) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS - 1)) state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (bus.rdy_tx) begin
          if (nl_q && (cnt_q == CW'(DIGITS))) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers; reset aborts any word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // outputs decoded from state only, so they hold steady through a stall
  always_comb begin
    bus.vld_tx = (state_q != ST_IDLE);
    bus.busy   = (state_q != ST_IDLE);
    bus.rdy_in = (state_q == ST_IDLE) && !rst;
    case (state_q)
      ST_DIGIT: bus.d_tx = nib_asc;
      ST_TERM:  bus.d_tx = nl_q ? ((cnt_q == CW'(DIGITS)) ? ASC_CR : ASC_LF) : ASC_SP;
      default:  bus.d_tx = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_hex_printer.sv
// Self-checking bench: two printers (8 and 2 digits) against a character-queue model.
// Latency: n/a.
// Backpressure: rdy_tx driven tied-high, 1-of-3, or random.
module tb_hex_printer;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        nl;
  logic        vld_in;
  logic        rdy_tx;
  int          mode;
  int          cyc;
  int          n_checks;
  int          n_fail;

  logic [7:0] exp_q   [2][$];
  logic [7:0] sent    [2][$];
  int         tx_cyc  [2][$];
  int         acc_cyc [2][$];

  hex_printer_if if8 ();
  hex_printer_if if2 ();

  assign if8.din    = din;
  assign if8.nl     = nl;
  assign if8.vld_in = vld_in;
  assign if8.rdy_tx = rdy_tx;
  assign if2.din    = din;
  assign if2.nl     = nl;
  assign if2.vld_in = vld_in;
  assign if2.rdy_tx = rdy_tx;

  hex_printer #(.DIGITS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  hex_printer #(.DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // The text a printer must emit for one accepted word.
  task automatic model_push(input int k, input logic [31:0] w, input logic n, input int digits);
    int v;
    for (int i = digits - 1; i >= 0; i--) begin
      v = int'((w >> (4 * i)) & 32'hF);
      if (v < 10) exp_q[k].push_back(8'(48 + v));
      else        exp_q[k].push_back(8'(65 + v - 10));
    end
    if (n) begin
      exp_q[k].push_back(8'd13);
      exp_q[k].push_back(8'd10);
    end else begin
      exp_q[k].push_back(8'd32);
    end
  endtask

  // Outputs are checked against the model, then the handshakes about to
  // happen at the next rising edge update the model.
  task automatic compare(input int k, input int digits, input logic r_in, input logic v_tx,
                         input logic bsy, input logic [7:0] d);
    logic pending;
    if (rst) begin
      chk($sformatf("dut%0d_rst_vld_tx", k), v_tx, 0);
      chk($sformatf("dut%0d_rst_busy", k), bsy, 0);
      chk($sformatf("dut%0d_rst_d_tx", k), d, 0);
      exp_q[k].delete();
      return;
    end
    pending = (exp_q[k].size() != 0);
    chk($sformatf("dut%0d_vld_tx", k), v_tx, pending);
    chk($sformatf("dut%0d_busy", k), bsy, pending);
    chk($sformatf("dut%0d_rdy_in", k), r_in, !pending);
    if (pending) chk($sformatf("dut%0d_d_tx", k), d, exp_q[k][0]);
    if (v_tx && rdy_tx) begin
      sent[k].push_back(d);
      tx_cyc[k].push_back(cyc);
      if (pending) void'(exp_q[k].pop_front());
    end
    if (vld_in && r_in) begin
      model_push(k, din, nl, digits);
      acc_cyc[k].push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    compare(0, 8, if8.rdy_in, if8.vld_tx, if8.busy, if8.d_tx);
    compare(1, 2, if2.rdy_in, if2.vld_tx, if2.busy, if2.d_tx);
  end

  // character-side backpressure pattern
  initial begin
    int ph;
    ph = 0;
    rdy_tx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       begin rdy_tx = (ph == 0); ph = (ph + 1) % 3; end
        2:       rdy_tx = 1'($urandom_range(0, 1));
        default: rdy_tx = 1'b1;
      endcase
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      sent[k].delete();
      tx_cyc[k].delete();
      acc_cyc[k].delete();
    end
  endtask

  task automatic chk_log(input int k, input string name, input string s);
    chk({name, "_len"}, sent[k].size(), s.len());
    for (int i = 0; i < s.len() && i < sent[k].size(); i++) begin
      chk($sformatf("%s_ch%0d", name, i), sent[k][i], s[i]);
    end
  endtask

  // offer a word until the 8-digit printer takes it
  task automatic accept_word(input logic [31:0] w, input logic n, input bit keep);
    bit got;
    got = 0;
    din = w;
    nl = n;
    vld_in = 1'b1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (if8.rdy_in) got = 1;
    end
    if (!got) fail_timeout("accept_word");
    @(posedge clk);
    #1;
    if (!keep) vld_in = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!if8.busy && !if2.busy && !vld_in) done = 1;
    end
    if (!done) fail_timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    mode = 0;
    rst = 1'b1;
    din = '0;
    nl = 1'b0;
    vld_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_rdy_in", if8.rdy_in, 1);
    chk("reset_d_tx", if8.d_tx, 0);
    @(posedge clk);
    #1;

    // one word, CR LF, no backpressure: 10 characters on consecutive cycles
    clear_logs();
    accept_word(32'h1234ABCD, 1'b1, 1'b0);
    wait_idle();
    chk_log(0, "s1_seq", "1234ABCD\r\n");
    chk_log(1, "s1_d2_seq", "CD\r\n");
    chk("s1_first_lat", tx_cyc[0][0], acc_cyc[0][0] + 1);
    chk("s1_last_cyc", tx_cyc[0][9], acc_cyc[0][0] + 10);

    // space terminator with rdy_tx high one cycle in three
    clear_logs();
    mode = 1;
    accept_word(32'h0000000F, 1'b0, 1'b0);
    wait_idle();
    chk_log(0, "s2_seq", "0000000F ");
    mode = 0;

    // back-to-back words with vld_in held high
    clear_logs();
    accept_word(32'hDEADBEEF, 1'b1, 1'b1);
    accept_word(32'h00000001, 1'b1, 1'b0);
    wait_idle();
    chk("s3_count", sent[0].size(), 20);
    chk("s3_b2b", acc_cyc[0][1], tx_cyc[0][9] + 1);
    chk_log(0, "s3_seq", "DEADBEEF\r\n00000001\r\n");

    // a word offered while busy is ignored
    clear_logs();
    accept_word(32'h89ABCDEF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    din = 32'hFFFFFFFF;
    vld_in = 1'b1;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    wait_idle();
    chk_log(0, "s4_seq", "89ABCDEF ");
    chk("s4_accepts", acc_cyc[0].size(), 1);

    // reset in the middle of a word
    clear_logs();
    accept_word(32'hCAFEBABE, 1'b1, 1'b0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (sent[0].size() == 3) got = 1;
    end
    if (!got) fail_timeout("s5_third_char");
    #1;
    chk("s5_vld_before_rst", if8.vld_tx, 1);
    rst = 1'b1;
    #1;
    chk("s5_async_vld_tx", if8.vld_tx, 0);
    chk("s5_async_busy", if8.busy, 0);
    chk("s5_async_d_tx", if8.d_tx, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s5_rdy_in_after", if8.rdy_in, 1);
    repeat (10) @(posedge clk);
    #1;
    chk_log(0, "s5_seq", "CAF");

    // two-digit printer
    clear_logs();
    accept_word(32'h0000003C, 1'b1, 1'b0);
    wait_idle();
    chk_log(1, "s6_d2_seq", "3C\r\n");
    chk_log(0, "s6_d8_seq", "0000003C\r\n");

    // random words, random gaps, random backpressure, stray offers while busy
    mode = 2;
    for (int w = 0; w < 30; w++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      accept_word($urandom, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        din = $urandom;
        vld_in = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
      end
    end
    wait_idle();
    mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_printer.md
HEX_PRINTER -- requirements
Module: hex_printer

Interface
REQ-001 Parameter DIGITS, default 8: number of hex nibbles printed per word (legal range 1..8).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  32  word to print; least-significant 4*DIGITS bits are used.
REQ-005 nl  input  1  terminator select, sampled with din: 1 = CR LF, 0 = single space.
REQ-006 vld_in  input  1  upstream word valid.
REQ-007 rdy_in  output  1  block ready to accept a word.
REQ-008 d_tx  output  8  ASCII character to the UART transmitter.
REQ-009 vld_tx  output  1  d_tx valid.
REQ-010 rdy_tx  input  1  UART transmitter ready.
REQ-011 busy  output  1  high whenever a word is being printed (state != IDLE).

Function
REQ-012 A transfer SHALL occur on a port in any cycle where its vld and rdy are both high at the clock edge.
REQ-013 States SHALL be IDLE, DIGIT and TERM.
REQ-014 IDLE: rdy_in=1, vld_tx=0, busy=0. On vld_in&&rdy_in, the block SHALL latch din[4*DIGITS-1:0] and nl, clear the digit counter, and enter DIGIT.
REQ-015 The first vld_tx SHALL assert in the cycle after the accepting edge (latency 1 cycle).
REQ-016 DIGIT: vld_tx=1; d_tx = ASCII of the nibble at counter position, MSB nibble first. Counter SHALL advance only on vld_tx&&rdy_tx. After the DIGITS-th transfer, the block SHALL enter TERM.
REQ-017 Nibble mapping SHALL be 0..9 -> 0x30..0x39 and A..F -> 0x41..0x46 (uppercase only).
REQ-018 TERM with latched nl=1: the block SHALL send 0x0D then 0x0A. With nl=0: it SHALL send 0x20. After the last terminator transfer, the block SHALL return to IDLE.
REQ-019 Once vld_tx is asserted, vld_tx and d_tx SHALL stay stable until rdy_tx is sampled high.
REQ-020 rdy_in SHALL be 0 in DIGIT and TERM. vld_in asserted while busy SHALL be ignored and SHALL not corrupt the latched word.
REQ-021 Back-to-back: rdy_in SHALL be 1 in the cycle after the final terminator transfer. No extra idle cycle beyond that is permitted.
REQ-022 rdy_tx held low indefinitely SHALL stall the block with no loss or repetition of characters.
REQ-023 A word of one full print SHALL emit exactly DIGITS+2 characters (nl=1) or DIGITS+1 characters (nl=0).

Reset
REQ-024 On rst assertion, the block SHALL immediately enter IDLE with vld_tx=0, busy=0, d_tx=0x00, counter=0 and the latched word cleared; rdy_in SHALL be 1 once rst is deasserted.
REQ-025 Reset mid-print SHALL abort the word. No further characters of it SHALL be emitted after release.

Structure
REQ-026 A shared package SHALL hold the state encoding and the ASCII constants CR (0x0D), LF (0x0A), SP (0x20), '0' (0x30) and 'A' (0x41).
REQ-027 One sub-module, hex2ascii (4-bit in, 8-bit out, combinational), SHALL perform the nibble-to-ASCII mapping.
REQ-028 The block SHALL contain a single FSM with a counter of width clog2(DIGITS+2) and a data register of width 4*DIGITS+1.

Verification
REQ-029 Scenario: DIGITS=8, din=0x1234ABCD, nl=1, rdy_tx tied 1 -> d_tx sequence 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A on 10 consecutive cycles starting 1 cycle after accept.
REQ-030 Scenario: din=0x0000000F, nl=0, rdy_tx toggling 1-of-3 cycles -> "0000000F " emitted in order, no duplicates, d_tx stable during stalls.
REQ-031 Scenario: two words 0xDEADBEEF then 0x00000001 with vld_in held high -> second word accepted in the cycle after the first word's LF; 20 characters total.
REQ-032 Scenario: vld_in pulses with din=0xFFFFFFFF while printing 0x89ABCDEF -> output unaffected; the pulse is not accepted.
REQ-033 Scenario: rst asserted after the 3rd character of 0xCAFEBABE -> vld_tx=0 asynchronously; after release, rdy_in=1 and no stray characters are emitted.
REQ-034 Scenario: DIGITS=2, din=0x0000003C, nl=1 -> 0x33 0x43 0x0D 0x0A.
